// File: rtl/axis_fifo_pkg.sv
// Shared constants and elaboration helpers for the AXI-Stream FIFO slice.
package axis_fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_FIFO_DEPTH = 16;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// Simple dual-port RAM: synchronous write, asynchronous read, no reset.
module fifo_ram_sdp
    import axis_fifo_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_DATA_WIDTH + 1,
    parameter int unsigned DEPTH      = DEFAULT_FIFO_DEPTH,
    parameter int unsigned ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/axis_stream_fifo.sv
// AXI-Stream FIFO: RAM of {tlast, tdata} followed by one output register,
// with bypass into the output register when the RAM is empty.
module axis_stream_fifo
    import axis_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = DEFAULT_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH      = DEFAULT_FIFO_DEPTH,
    parameter int unsigned ALMOST_FULL_TH  = FIFO_DEPTH - 2,
    parameter int unsigned ALMOST_EMPTY_TH = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              flush,
    input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
    input  logic                              s_axis_tlast,
    input  logic                              s_axis_tvalid,
    output logic                              s_axis_tready,
    output logic [DATA_WIDTH-1:0]             m_axis_tdata,
    output logic                              m_axis_tlast,
    output logic                              m_axis_tvalid,
    input  logic                              m_axis_tready,
    output logic [clog2(FIFO_DEPTH+1)-1:0]    level,
    output logic                              almost_full,
    output logic                              almost_empty
);

    localparam int unsigned AW = clog2(FIFO_DEPTH);
    localparam int unsigned LW = clog2(FIFO_DEPTH + 1);
    localparam logic [LW-1:0] DEPTH_LVL = LW'(FIFO_DEPTH);
    localparam logic [LW-1:0] AF_LVL    = LW'(ALMOST_FULL_TH);
    localparam logic [LW-1:0] AE_LVL    = LW'(ALMOST_EMPTY_TH);

    if (FIFO_DEPTH < 4 || FIFO_DEPTH > 4096 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two in 4..4096");
    end
    if (DATA_WIDTH < 8 || DATA_WIDTH > 1024) begin : g_bad_width
        $error("DATA_WIDTH must be in 8..1024");
    end
    if (ALMOST_FULL_TH > FIFO_DEPTH || ALMOST_EMPTY_TH > FIFO_DEPTH) begin : g_bad_thresh
        $error("ALMOST_* thresholds must lie within 0..FIFO_DEPTH");
    end

    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]       level_next;
    logic                push, pop, out_load, ram_empty, bypass;
    logic                ram_wr_en, ram_rd_en;
    logic [DATA_WIDTH:0] ram_rd_data;

    // The output register reloads whenever it is free, so the RAM never holds
    // more than FIFO_DEPTH-1 words and equal pointers always mean empty.
    always_comb begin
        push       = s_axis_tvalid & s_axis_tready;
        pop        = m_axis_tvalid & m_axis_tready;
        ram_empty  = (wr_ptr == rd_ptr);
        out_load   = ~m_axis_tvalid | pop;
        bypass     = out_load & ram_empty & push;
        ram_wr_en  = push & ~bypass & ~flush;
        ram_rd_en  = out_load & ~ram_empty;
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    fifo_ram_sdp #(
        .WIDTH      (DATA_WIDTH + 1),
        .DEPTH      (FIFO_DEPTH),
        .ADDR_WIDTH (AW)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_wr_en),
        .wr_addr (wr_ptr),
        .wr_data ({s_axis_tlast, s_axis_tdata}),
        .rd_addr (rd_ptr),
        .rd_data (ram_rd_data)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            s_axis_tready <= 1'b0;
            almost_full   <= 1'b0;
            almost_empty  <= 1'b1;
        end else if (flush) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            level         <= '0;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b1;
            almost_full   <= (AF_LVL == '0);
            almost_empty  <= 1'b1;
        end else begin
            if (ram_wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ram_rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (out_load) begin
                if (ram_rd_en) begin
                    {m_axis_tlast, m_axis_tdata} <= ram_rd_data;
                    m_axis_tvalid <= 1'b1;
                end else if (bypass) begin
                    {m_axis_tlast, m_axis_tdata} <= {s_axis_tlast, s_axis_tdata};
                    m_axis_tvalid <= 1'b1;
                end else begin
                    m_axis_tvalid <= 1'b0;
                end
            end
            level         <= level_next;
            s_axis_tready <= (level_next < DEPTH_LVL);
            almost_full   <= (level_next >= AF_LVL);
            almost_empty  <= (level_next <= AE_LVL);
        end
    end

endmodule
